// File: rtl/keypad_entry.sv
// keypad_entry
// Keypad-side writer for the microwave countdown timer. Debounces the
// one-hot keypad, shifts accepted digits into a 3-digit BCD entry register,
// and issues load/clear pulses toward the timer.
//
// Ports:
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   keypad     10-line one-hot keypad (bit i = digit i)
//   startn     active-low start button (synchronous)
//   clearn     active-low clear button (synchronous)
//   mag_on     magnetron running; entry locked while high
//   entry      live entry {min, sec_tens, sec_ones}
//   data       timer load value, updated only with load
//   load       one-cycle pulse: timer loads data
//   clear      one-cycle pulse: timer clears
//   key_valid  one-cycle pulse per digit shifted into entry
//   dbg_state  current debounce FSM state (0 IDLE, 1 PRESS, 2 HELD, 3 RELEASE)
//
// Handshake: there is no backpressure. load, clear and key_valid are
// registered single-cycle strobes; data is valid from the load strobe until
// the next load strobe.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [9:0]  keypad,
  input  logic        startn,
  input  logic        clearn,
  input  logic        mag_on,
  output logic [11:0] entry,
  output logic [11:0] data,
  output logic        load,
  output logic        clear,
  output logic        key_valid,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] DB = 8'(DEBOUNCE_CYCLES);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [3:0]  r_cand;
  logic [9:0]  r_kq;
  logic [11:0] r_entry;
  logic [11:0] r_data;
  logic        r_load;
  logic        r_clear;
  logic        r_key_valid;
  logic        r_startn_q;
  logic        r_clearn_q;

  state_t      w_state_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [3:0]  w_cand_nxt;
  logic        w_accept;
  logic        w_onehot;
  logic [3:0]  w_code;
  logic [3:0]  w_digit;
  logic        w_start_ev;
  logic        w_clear_ev;
  logic [3:0]  w_tens_clamped;

  // A power-of-two test rejects both "no key" and multi-key combinations.
  assign w_onehot = (r_kq != 10'd0) && ((r_kq & (r_kq - 10'd1)) == 10'd0);

  always_comb begin
    w_code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (r_kq[i]) w_code = 4'(i);
    end
  end

  // With DEBOUNCE_CYCLES=1 a key is accepted straight from IDLE, so the
  // shifted digit is the live code rather than the latched candidate.
  assign w_digit = (r_state == IDLE) ? w_code : r_cand;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_cand  <= 4'd0;
      r_kq    <= 10'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
      r_kq    <= keypad;
    end
  end

  // The count includes the current cycle, so compare cnt+1 against the
  // threshold; this lands acceptance DEBOUNCE_CYCLES+1 edges after the press.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_onehot) begin
          w_cand_nxt = w_code;
          w_cnt_nxt  = 8'd1;
          if (DB <= 8'd1) begin
            w_accept    = 1'b1;
            w_state_nxt = HELD;
          end else begin
            w_state_nxt = PRESS;
          end
        end
      end
      PRESS: begin
        if (w_onehot && (w_code == r_cand)) begin
          w_cnt_nxt = r_cnt + 8'd1;
          if ((r_cnt + 8'd1) >= DB) begin
            w_accept    = 1'b1;
            w_state_nxt = HELD;
          end
        end else begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = IDLE;
        end
      end
      HELD: begin
        if (r_kq == 10'd0) begin
          if (DB <= 8'd1) begin
            w_cnt_nxt   = 8'd0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt   = 8'd1;
            w_state_nxt = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (r_kq != 10'd0) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = HELD;
        end else if ((r_cnt + 8'd1) >= DB) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_cnt_nxt   = 8'd0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_start_ev     = r_startn_q & ~startn;
  assign w_clear_ev     = r_clearn_q & ~clearn;
  assign w_tens_clamped = (r_entry[7:4] > 4'd5) ? 4'd5 : r_entry[7:4];

  // Priority: clear, then start, then digit shift. A start that is ignored
  // (empty entry or magnetron on) does not block a digit in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_entry     <= 12'd0;
      r_data      <= 12'd0;
      r_load      <= 1'b0;
      r_clear     <= 1'b0;
      r_key_valid <= 1'b0;
      r_startn_q  <= 1'b1;
      r_clearn_q  <= 1'b1;
    end else begin
      r_startn_q  <= startn;
      r_clearn_q  <= clearn;
      r_load      <= 1'b0;
      r_key_valid <= 1'b0;
      r_clear     <= w_clear_ev;
      if (!clearn) begin
        r_entry <= 12'd0;
      end else if (w_start_ev && !mag_on && (r_entry != 12'd0)) begin
        r_data  <= {r_entry[11:8], w_tens_clamped, r_entry[3:0]};
        r_load  <= 1'b1;
        r_entry <= 12'd0;
      end else if (w_accept && !mag_on) begin
        r_entry     <= {r_entry[7:0], w_digit};
        r_key_valid <= 1'b1;
      end
    end
  end

  assign entry     = r_entry;
  assign data      = r_data;
  assign load      = r_load;
  assign clear     = r_clear;
  assign key_valid = r_key_valid;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_keypad_entry.sv
module tb_keypad_entry;

  localparam int D = 4;

  // clock / reset
  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  keypad;
  logic        startn;
  logic        clearn;
  logic        mag_on;
  logic [11:0] entry;
  logic [11:0] data;
  logic        load;
  logic        clear;
  logic        key_valid;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  keypad_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .keypad    (keypad),
    .startn    (startn),
    .clearn    (clearn),
    .mag_on    (mag_on),
    .entry     (entry),
    .data      (data),
    .load      (load),
    .clear     (clear),
    .key_valid (key_valid),
    .dbg_state (dbg_state)
  );

  // scoreboard
  logic [11:0] exp_q[$];
  logic [11:0] model;
  int n_checks = 0;
  int n_fail   = 0;
  int n_exp_kv = 0;
  int kv_cnt   = 0;
  int load_cnt = 0;
  int clr_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every key_valid strobe must match the next expected entry value.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (key_valid === 1'b1) begin
        kv_cnt++;
        if (exp_q.size() == 0) check_eq("kv_unexpected", 32'd1, 32'd0);
        else check_eq("kv_entry", {20'd0, entry}, {20'd0, exp_q.pop_front()});
      end
      if (load === 1'b1) load_cnt++;
      if (clear === 1'b1) clr_cnt++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_digit(input logic [3:0] d);
    model = {model[7:0], d};
    exp_q.push_back(model);
    n_exp_kv++;
  endtask

  task automatic press_key(input int d, input int hold, input int rel);
    keypad = 10'd1 << d;
    repeat (hold) tick();
    keypad = 10'd0;
    repeat (rel) tick();
  endtask

  task automatic enter_digit(input int d);
    expect_digit(4'(d));
    press_key(d, 6, 6);
  endtask

  int kv_before;

  initial begin
    resetn = 1'b0;
    keypad = 10'd0;
    startn = 1'b1;
    clearn = 1'b1;
    mag_on = 1'b0;
    model  = 12'd0;
    repeat (3) tick();

    // reset state
    check_eq("rst_entry", {20'd0, entry}, 32'h0);
    check_eq("rst_data", {20'd0, data}, 32'h0);
    check_eq("rst_load", {31'd0, load}, 32'd0);
    check_eq("rst_clear", {31'd0, clear}, 32'd0);
    check_eq("rst_kv", {31'd0, key_valid}, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    resetn = 1'b1;
    repeat (2) tick();

    // digit entry: first press latency is D+1 edges
    expect_digit(4'd1);
    keypad = 10'd1 << 1;
    repeat (D) tick();
    check_eq("lat_kv_early", {31'd0, key_valid}, 32'd0);
    tick();
    check_eq("lat_kv", {31'd0, key_valid}, 32'd1);
    check_eq("lat_entry", {20'd0, entry}, 32'h001);
    tick();
    check_eq("lat_kv_width", {31'd0, key_valid}, 32'd0);
    keypad = 10'd0;
    repeat (6) tick();
    enter_digit(3);
    enter_digit(0);
    check_eq("entry_130", {20'd0, entry}, 32'h130);
    check_eq("kv_three", kv_cnt, 32'd3);

    // bounce rejection: short glitch, then two keys at once
    kv_before = kv_cnt;
    press_key(7, 3, 4);
    keypad = (10'd1 << 2) | (10'd1 << 5);
    repeat (10) tick();
    keypad = 10'd0;
    repeat (6) tick();
    check_eq("bounce_kv", kv_cnt, kv_before);
    check_eq("bounce_entry", {20'd0, entry}, 32'h130);

    // overflow and long hold
    enter_digit(1);
    enter_digit(2);
    enter_digit(3);
    enter_digit(4);
    check_eq("ovf_entry", {20'd0, entry}, 32'h234);
    kv_before = kv_cnt;
    expect_digit(4'd9);
    press_key(9, 50, 6);
    check_eq("hold_one_kv", kv_cnt, kv_before + 1);
    check_eq("hold_entry", {20'd0, entry}, 32'h349);

    // clear held for several cycles: one pulse, data untouched
    clearn = 1'b0;
    tick();
    model = 12'd0;
    check_eq("clr_pulse", {31'd0, clear}, 32'd1);
    check_eq("clr_entry", {20'd0, entry}, 32'h0);
    tick();
    check_eq("clr_width", {31'd0, clear}, 32'd0);
    tick();
    clearn = 1'b1;
    tick();
    check_eq("clr_count", clr_cnt, 32'd1);
    check_eq("clr_data", {20'd0, data}, 32'h0);

    // start with sec_tens clamp
    enter_digit(1);
    enter_digit(8);
    enter_digit(5);
    check_eq("pre_start_entry", {20'd0, entry}, 32'h185);
    startn = 1'b0;
    tick();
    model = 12'd0;
    check_eq("start_load", {31'd0, load}, 32'd1);
    check_eq("start_data", {20'd0, data}, 32'h155);
    check_eq("start_entry", {20'd0, entry}, 32'h0);
    tick();
    check_eq("start_load_width", {31'd0, load}, 32'd0);
    repeat (3) tick();
    startn = 1'b1;
    tick();
    check_eq("start_one_load", load_cnt, 32'd1);

    // start with empty entry is ignored
    startn = 1'b0;
    tick();
    check_eq("empty_start_load", {31'd0, load}, 32'd0);
    tick();
    startn = 1'b1;
    tick();
    check_eq("empty_start_cnt", load_cnt, 32'd1);
    check_eq("empty_start_data", {20'd0, data}, 32'h155);

    // magnetron lock
    kv_before = kv_cnt;
    mag_on = 1'b1;
    press_key(4, 6, 6);
    mag_on = 1'b0;
    check_eq("lock_kv", kv_cnt, kv_before);
    check_eq("lock_entry", {20'd0, entry}, 32'h0);

    // clear beats start
    enter_digit(0);
    enter_digit(4);
    enter_digit(5);
    check_eq("prio_pre_entry", {20'd0, entry}, 32'h045);
    clearn = 1'b0;
    startn = 1'b0;
    tick();
    model = 12'd0;
    check_eq("prio_clear", {31'd0, clear}, 32'd1);
    check_eq("prio_load", {31'd0, load}, 32'd0);
    check_eq("prio_entry", {20'd0, entry}, 32'h0);
    check_eq("prio_data", {20'd0, data}, 32'h155);
    tick();
    clearn = 1'b1;
    startn = 1'b1;
    repeat (2) tick();

    // reset mid-debounce with key held
    enter_digit(6);
    check_eq("pre_rst_entry", {20'd0, entry}, 32'h006);
    keypad = 10'd1 << 6;
    repeat (2) tick();
    check_eq("mid_state_press", {30'd0, dbg_state}, 32'd1);
    resetn = 1'b0;
    #1;
    model = 12'd0;
    check_eq("mid_rst_entry", {20'd0, entry}, 32'h0);
    check_eq("mid_rst_data", {20'd0, data}, 32'h0);
    check_eq("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    expect_digit(4'd6);
    repeat (D) tick();
    check_eq("post_rst_kv_early", {31'd0, key_valid}, 32'd0);
    tick();
    check_eq("post_rst_kv", {31'd0, key_valid}, 32'd1);
    check_eq("post_rst_entry", {20'd0, entry}, 32'h006);
    keypad = 10'd0;
    repeat (8) tick();

    // final report
    check_eq("kv_total", kv_cnt, n_exp_kv);
    check_eq("exp_q_empty", exp_q.size(), 32'd0);
    check_eq("clear_total", clr_cnt, 32'd2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Keypad-side writer for the microwave countdown timer. It debounces and encodes the 10-line one-hot keypad and shifts accepted digits into a 3-digit BCD entry register (minutes, seconds tens, seconds ones). On start it hands the entry to the timer as a parallel load with a one-cycle `load` pulse, and on clear it issues a `clear` pulse. It sits between the raw front-panel inputs and the timer's data/load/clear inputs; its entry digits also feed the 7-segment decoders while the oven is idle.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a press or a release; legal range 1..255.
- `clk`  in  1  single system clock, rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `keypad`  in  10  bit i high means digit i is pressed; valid only when exactly one bit is set.
- `startn`  in  1  active-low start button, synchronous to `clk`.
- `clearn`  in  1  active-low clear button, synchronous to `clk`.
- `mag_on`  in  1  magnetron running; entry is locked while high.
- `entry`  out  12  live entry {min, sec_tens, sec_ones}, 4-bit BCD each.
- `data`  out  12  timer load value {min, sec_tens, sec_ones}; stable from the `load` pulse until the next load.
- `load`  out  1  one-cycle pulse: timer loads `data`.
- `clear`  out  1  one-cycle pulse: timer clears.
- `key_valid`  out  1  one-cycle pulse per accepted digit.

## Operation
- **Reset values.** While `resetn` is low, all outputs are 0, the FSM is in IDLE, the counter is 0, and `startn_q` is 1. Reset mid-press returns to IDLE. A key still held after reset must pass the full debounce before it is accepted.
- **Input stage.** `keypad` is registered once into `kq`. `code` is the 4-bit binary index of `kq` when `kq` is one-hot. Zero bits set, or more than one bit set, counts as "no key".
- **FSM.**
  - IDLE: on a valid `code`, latch `code` into `cand`, set cnt=1, and go to PRESS.
  - PRESS: while `code`==`cand`, increment cnt. If `kq` changes, or becomes invalid or zero, return to IDLE with cnt=0.
  - PRESS to HELD: when cnt reaches DEBOUNCE_CYCLES, accept the key and go to HELD.
  - Accepting a key while `mag_on`=0: `key_valid`=1 and entry shifts as min<=sec_tens, sec_tens<=sec_ones, sec_ones<=`cand`. A 4th digit drops the old minutes digit.
  - Accepting a key while `mag_on`=1: no shift and no `key_valid`, but the FSM still goes to HELD.
  - HELD: when `kq`==0, set cnt=1 and go to RELEASE.
  - RELEASE: while `kq`==0, increment cnt. Any nonzero `kq` returns to HELD. When cnt reaches DEBOUNCE_CYCLES, go to IDLE.
  - A held key produces exactly one digit. A second key pressed before release is ignored.
- **Start.** `startn_q` is the registered `startn`. A start event is `startn_q`=1 and `startn`=0, i.e. a falling edge.
  - If `mag_on`=0 and `entry`!=0: `data`<=`entry` with sec_tens clamped to 5 if above 5, `load`=1, and `entry` clears on the same edge.
  - If `entry`==0 or `mag_on`=1: the start event is ignored. No load is issued.
- **Clear.** While `clearn`=0, `entry`<=0, and `clear` pulses once per `clearn` low level (on its falling edge). `data` is unchanged.
- **Simultaneous events.** Clear beats start, and start beats a digit shift in the same cycle; the lower-priority action is dropped.
- BCD digits are always 0..9 because codes come from a one-hot index. No arithmetic carries occur.

## Timing
- A keypad change first appears in `kq` one cycle later. A press that is stable from cycle 0 produces `key_valid` and the updated `entry` at the edge ending cycle DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+1 edges after the change.
- Minimum period per digit: 2·DEBOUNCE_CYCLES+2 cycles.
- Start: `startn` goes low at cycle n; `load`, `data`, and `entry`=0 take effect at edge n+1; `load` is low at n+2.
- Clear: `clear` is high one cycle after `clearn` falls; `entry`=0 on that same edge.
- `load`, `clear`, and `key_valid` are registered and each is exactly one cycle wide.

## Test plan
- **Digit entry.** DEBOUNCE_CYCLES=4; press 1, 3, 0, each held 6 cycles with 6 cycles released → three `key_valid` pulses, `entry`=0x130, first pulse 5 edges after the press.
- **Bounce rejection.** A 3-cycle glitch on key 7, then a two-key press {2,5} held 10 cycles → no `key_valid`, `entry` unchanged.
- **Overflow.** Enter 1,2,3,4 → `entry`=0x234. Hold key 9 for 50 cycles → exactly one shift.
- **Start with clamp.** Enter 1,8,5, then `startn` low for 5 cycles → a single `load` pulse, `data`=0x155, `entry`=0. Start with `entry`=0 → no `load`.
- **Lock and priority.** With `mag_on`=1, press 4 → no shift and no `key_valid`. With `entry`=0x045, assert `clearn` and `startn` low in the same cycle → `clear`=1, `load`=0, `entry`=0.
- **Reset mid-operation.** Assert `resetn` low mid-debounce while key 6 is held → outputs 0. Release reset with key 6 still held → `key_valid` only after a full DEBOUNCE_CYCLES+1 cycles.
